// File: rtl/rv32i_decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : rv32i_decode_stage
// Purpose  : RV32I decode stage in front of the ALU. Captures one fetched
//            instruction per handshake, samples the register file read data
//            at that same moment, and presents a registered decoded bundle
//            (ALU op, operands, immediate, rd, control flags) to EX.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Configuration macro:
//   DECODE_SKID_EN : adds a one-entry skid buffer holding a full decoded
//                    bundle; if_ready then comes straight from a flop
//                    (!skid_valid) with no combinational path from ex_ready.
//                    Undefined (default): if_ready = !ex_valid | ex_ready.
// ----------------------------------------------------------------------------
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   flush                 drop held bundle(s) and any incoming instruction
//   if_valid/if_ready     fetch-side handshake
//   if_instr, if_pc       instruction word and its address
//   rs1_addr, rs2_addr    register file read addresses (combinational)
//   rs1_data, rs2_data    register file read data, same cycle as address
//   ex_valid/ex_ready     EX-side handshake
//   ex_alu_op/a/b         ALU op code and operands
//   ex_imm, ex_pc, ex_rd  immediate, instruction PC, destination register
//   ex_reg_we, ex_funct3  rd write enable, funct3 passthrough
//   ex_is_*               branch / jal / jalr / load / store flags
//   ex_illegal            unrecognised encoding
// ============================================================================
module rv32i_decode_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        if_valid,
    output logic        if_ready,
    input  logic [31:0] if_instr,
    input  logic [31:0] if_pc,
    output logic [4:0]  rs1_addr,
    output logic [4:0]  rs2_addr,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    output logic        ex_valid,
    input  logic        ex_ready,
    output logic [4:0]  ex_alu_op,
    output logic [31:0] ex_alu_a,
    output logic [31:0] ex_alu_b,
    output logic [31:0] ex_imm,
    output logic [31:0] ex_pc,
    output logic [4:0]  ex_rd,
    output logic        ex_reg_we,
    output logic [2:0]  ex_funct3,
    output logic        ex_is_branch,
    output logic        ex_is_jal,
    output logic        ex_is_jalr,
    output logic        ex_is_load,
    output logic        ex_is_store,
    output logic        ex_illegal
);

    typedef struct packed {
        logic [4:0]  alu_op;
        logic [31:0] alu_a;
        logic [31:0] alu_b;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        reg_we;
        logic [2:0]  funct3;
        logic        is_branch;
        logic        is_jal;
        logic        is_jalr;
        logic        is_load;
        logic        is_store;
        logic        illegal;
    } bundle_t;

    localparam logic [6:0] c_OPC_OP     = 7'b0110011;
    localparam logic [6:0] c_OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OPC_STORE  = 7'b0100011;
    localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
    localparam logic [6:0] c_OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OPC_JAL    = 7'b1101111;
    localparam logic [6:0] c_OPC_JALR   = 7'b1100111;

    localparam logic [4:0] c_ALU_ADD    = 5'b00000;
    localparam logic [6:0] c_F7_ZERO    = 7'b0000000;
    localparam logic [6:0] c_F7_ALT     = 7'b0100000;

    localparam bundle_t c_RST_BUNDLE = '{pc: RESET_PC, default: '0};

    // ------------------------------------------------------------------
    // Instruction fields and immediates
    // ------------------------------------------------------------------
    logic [6:0]  w_opcode;
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    logic [4:0]  w_rd;
    logic [4:0]  w_shamt;
    logic [31:0] w_imm_i;
    logic [31:0] w_imm_s;
    logic [31:0] w_imm_b;
    logic [31:0] w_imm_u;
    logic [31:0] w_imm_j;

    assign w_opcode = if_instr[6:0];
    assign w_rd     = if_instr[11:7];
    assign w_f3     = if_instr[14:12];
    assign w_f7     = if_instr[31:25];
    assign w_shamt  = if_instr[24:20];

    assign w_imm_i = {{20{if_instr[31]}}, if_instr[31:20]};
    assign w_imm_s = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
    assign w_imm_b = {{19{if_instr[31]}}, if_instr[31], if_instr[7],
                      if_instr[30:25], if_instr[11:8], 1'b0};
    assign w_imm_u = {if_instr[31:12], 12'b0};
    assign w_imm_j = {{11{if_instr[31]}}, if_instr[31], if_instr[19:12],
                      if_instr[20], if_instr[30:21], 1'b0};

    assign rs1_addr = if_instr[19:15];
    assign rs2_addr = if_instr[24:20];

    // ------------------------------------------------------------------
    // Combinational decode of the instruction currently offered by fetch
    // ------------------------------------------------------------------
    bundle_t w_dec;
    logic    w_legal;

    always_comb begin
        w_dec        = '0;
        w_legal      = 1'b1;
        w_dec.pc     = if_pc;
        w_dec.rd     = w_rd;
        w_dec.funct3 = w_f3;
        w_dec.alu_op = c_ALU_ADD;

        case (w_opcode)
            c_OPC_OP: begin
                w_dec.alu_op = {1'b0, w_f7[5], w_f3};
                w_dec.alu_a  = rs1_data;
                w_dec.alu_b  = rs2_data;
                w_dec.reg_we = 1'b1;
                // Alternate funct7 only exists for SUB and SRA.
                w_legal = (w_f7 == c_F7_ZERO) ||
                          ((w_f7 == c_F7_ALT) && ((w_f3 == 3'b000) || (w_f3 == 3'b101)));
            end
            c_OPC_OP_IMM: begin
                // Bit 30 selects SRAI; for every other funct3 it is immediate data.
                w_dec.alu_op = {1'b0, (w_f3 == 3'b101) ? w_f7[5] : 1'b0, w_f3};
                w_dec.alu_a  = rs1_data;
                w_dec.alu_b  = w_imm_i;
                w_dec.imm    = w_imm_i;
                w_dec.reg_we = 1'b1;
                if (w_f3 == 3'b001) begin
                    w_dec.alu_b = {27'b0, w_shamt};
                    w_legal     = (w_f7 == c_F7_ZERO);
                end else if (w_f3 == 3'b101) begin
                    w_dec.alu_b = {27'b0, w_shamt};
                    w_legal     = (w_f7 == c_F7_ZERO) || (w_f7 == c_F7_ALT);
                end
            end
            c_OPC_BRANCH: begin
                w_dec.alu_op    = {2'b10, w_f3};
                w_dec.alu_a     = rs1_data;
                w_dec.alu_b     = rs2_data;
                w_dec.imm       = w_imm_b;
                w_dec.is_branch = 1'b1;
                w_legal         = (w_f3 != 3'b010) && (w_f3 != 3'b011);
            end
            c_OPC_LOAD: begin
                w_dec.alu_a   = rs1_data;
                w_dec.alu_b   = w_imm_i;
                w_dec.imm     = w_imm_i;
                w_dec.reg_we  = 1'b1;
                w_dec.is_load = 1'b1;
                // LB/LH/LW/LBU/LHU only.
                w_legal = (w_f3 != 3'b011) && (w_f3 != 3'b110) && (w_f3 != 3'b111);
            end
            c_OPC_STORE: begin
                w_dec.alu_a    = rs1_data;
                w_dec.alu_b    = w_imm_s;
                w_dec.imm      = w_imm_s;
                w_dec.is_store = 1'b1;
                w_legal        = (w_f3[2] == 1'b0) && (w_f3 != 3'b011);
            end
            c_OPC_LUI: begin
                w_dec.alu_a  = 32'h0;
                w_dec.alu_b  = w_imm_u;
                w_dec.imm    = w_imm_u;
                w_dec.reg_we = 1'b1;
            end
            c_OPC_AUIPC: begin
                w_dec.alu_a  = if_pc;
                w_dec.alu_b  = w_imm_u;
                w_dec.imm    = w_imm_u;
                w_dec.reg_we = 1'b1;
            end
            c_OPC_JAL: begin
                // ALU computes the link address; EX adds imm to pc for the target.
                w_dec.alu_a  = if_pc;
                w_dec.alu_b  = 32'd4;
                w_dec.imm    = w_imm_j;
                w_dec.reg_we = 1'b1;
                w_dec.is_jal = 1'b1;
            end
            c_OPC_JALR: begin
                w_dec.alu_a   = if_pc;
                w_dec.alu_b   = 32'd4;
                w_dec.imm     = w_imm_i;
                w_dec.reg_we  = 1'b1;
                w_dec.is_jalr = 1'b1;
                w_legal       = (w_f3 == 3'b000);
            end
            default: begin
                w_legal = 1'b0;
            end
        endcase

        if (!w_legal) begin
            w_dec.alu_op    = c_ALU_ADD;
            w_dec.alu_a     = 32'h0;
            w_dec.alu_b     = 32'h0;
            w_dec.imm       = 32'h0;
            w_dec.reg_we    = 1'b0;
            w_dec.is_branch = 1'b0;
            w_dec.is_jal    = 1'b0;
            w_dec.is_jalr   = 1'b0;
            w_dec.is_load   = 1'b0;
            w_dec.is_store  = 1'b0;
            w_dec.illegal   = 1'b1;
        end

        // x0 is hardwired; never request a write to it.
        if (w_rd == 5'd0) begin
            w_dec.reg_we = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Handshake and pipeline registers
    // ------------------------------------------------------------------
    bundle_t ex_q;
    bundle_t ex_d;
    logic    ex_valid_q;
    logic    ex_valid_d;
    logic    w_accept;

    // flush wins over an offered instruction even while if_ready is high.
    assign w_accept = if_valid && if_ready && !flush;

`ifdef DECODE_SKID_EN
    bundle_t skid_q;
    bundle_t skid_d;
    logic    skid_valid_q;
    logic    skid_valid_d;
    logic    w_ex_free;

    // Driven directly by a flop, so ex_ready never reaches if_ready combinationally.
    assign if_ready  = !skid_valid_q;
    assign w_ex_free = !ex_valid_q || ex_ready;

    always_comb begin
        ex_d         = ex_q;
        ex_valid_d   = ex_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            ex_valid_d   = 1'b0;
            skid_valid_d = 1'b0;
        end else if (w_ex_free) begin
            // The skid entry is older than anything fetch offers, so it goes first.
            // While it is full if_ready is low, so no accept can coincide.
            if (skid_valid_q) begin
                ex_d         = skid_q;
                ex_valid_d   = 1'b1;
                skid_valid_d = 1'b0;
            end else if (w_accept) begin
                ex_d       = w_dec;
                ex_valid_d = 1'b1;
            end else begin
                ex_valid_d = 1'b0;
            end
        end else if (w_accept) begin
            skid_d       = w_dec;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            skid_q       <= c_RST_BUNDLE;
            skid_valid_q <= 1'b0;
        end else begin
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
        end
    end
`else
    assign if_ready = !ex_valid_q || ex_ready;

    always_comb begin
        ex_d       = ex_q;
        ex_valid_d = ex_valid_q;
        if (flush) begin
            ex_valid_d = 1'b0;
        end else if (w_accept) begin
            ex_d       = w_dec;
            ex_valid_d = 1'b1;
        end else if (ex_ready) begin
            ex_valid_d = 1'b0;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_q       <= c_RST_BUNDLE;
            ex_valid_q <= 1'b0;
        end else begin
            ex_q       <= ex_d;
            ex_valid_q <= ex_valid_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign ex_valid     = ex_valid_q;
    assign ex_alu_op    = ex_q.alu_op;
    assign ex_alu_a     = ex_q.alu_a;
    assign ex_alu_b     = ex_q.alu_b;
    assign ex_imm       = ex_q.imm;
    assign ex_pc        = ex_q.pc;
    assign ex_rd        = ex_q.rd;
    assign ex_reg_we    = ex_q.reg_we;
    assign ex_funct3    = ex_q.funct3;
    assign ex_is_branch = ex_q.is_branch;
    assign ex_is_jal    = ex_q.is_jal;
    assign ex_is_jalr   = ex_q.is_jalr;
    assign ex_is_load   = ex_q.is_load;
    assign ex_is_store  = ex_q.is_store;
    assign ex_illegal   = ex_q.illegal;

endmodule

`default_nettype wire
